zorro2_autoconfig: RTL and testbench

- Zorro II AutoConfig responder for the IDE board; sits directly upstream of the IDE access/strobe block.
- Presents the 64 KB board's AutoConfig nybble ROM in config space $E80000-$E8007F while CFGIN_n is low, and latches the base address the OS writes.
- Once configured, decodes the board window and produces ide_access/ide_enable for the IDE block. Handles shut-up and passes config to the next board via CFGOUT_n.

---
 rtl/zorro2_autoconfig.sv | 88 ++++++++
 tb/tb_zorro2_autoconfig.sv | 139 +++++++++++++
 2 files changed

// File: rtl/zorro2_autoconfig.sv
// zorro2_autoconfig: Zorro II AutoConfig responder and board window decode for the IDE board
module zorro2_autoconfig #(
  parameter logic [15:0] MANUF_ID = 16'h07DB,
  parameter logic [7:0]  PROD_ID  = 8'h05,
  parameter logic [31:0] SERIAL   = 32'h00000001,
  parameter logic [15:0] DIAG_VEC = 16'h0000,
  parameter logic [7:0]  ER_TYPE  = 8'hD1
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [23:1] ADDR,
  input  logic [3:0]  DIN,
  input  logic        AS_n,
  input  logic        UDS_n,
  input  logic        LDS_n,
  input  logic        RW,
  input  logic        CFGIN_n,
  output logic        CFGOUT_n,
  output logic [3:0]  DOUT,
  output logic        DOE,
  output logic        ide_access,
  output logic        ide_enable,
  output logic        configured
);
  typedef enum logic [1:0] {UNCONFIG, CONFIGURED, SHUTUP} state_t;
  state_t state, state_n;
  logic [7:0] base, base_n, rom_byte, rom_val;
  logic [3:0] base_lo, base_lo_n;
  logic [4:0] rsel;
  logic [5:0] off;
  logic wr_done, wr_done_n, cfg_hit, commit;
  logic unused;
  assign unused = &{1'b0, LDS_n, ADDR[14:7]};
  assign rsel = ADDR[6:2];
  assign off = ADDR[6:1];
  assign cfg_hit = state == UNCONFIG && !CFGIN_n && !AS_n && ADDR[23:16] == 8'hE8;
  assign commit = cfg_hit && !RW && !UDS_n && !wr_done;
  always_comb begin
    rom_byte = 8'h00;
    case (rsel)
      5'd0:  rom_byte = ER_TYPE;
      5'd1:  rom_byte = PROD_ID;
      5'd4:  rom_byte = MANUF_ID[15:8];
      5'd5:  rom_byte = MANUF_ID[7:0];
      5'd6:  rom_byte = SERIAL[31:24];
      5'd7:  rom_byte = SERIAL[23:16];
      5'd8:  rom_byte = SERIAL[15:8];
      5'd9:  rom_byte = SERIAL[7:0];
      5'd10: rom_byte = DIAG_VEC[15:8];
      5'd11: rom_byte = DIAG_VEC[7:0];
      default: rom_byte = 8'h00;
    endcase
  end
  // Only er_type reads true; the rest of the first 16 registers read inverted, the upper 16 read zero
  assign rom_val = rsel == 5'd0 ? rom_byte : !rsel[4] ? ~rom_byte : 8'h00;
  assign DOE = cfg_hit && RW && !UDS_n;
  assign DOUT = !DOE ? 4'h0 : ADDR[1] ? rom_val[3:0] : rom_val[7:4];
  assign configured = state == CONFIGURED;
  assign CFGOUT_n = state == UNCONFIG;
  assign ide_access = configured && !AS_n && ADDR[23:16] == base;
  assign ide_enable = ide_access && ADDR[15];
  // wr_done limits each bus cycle to one commit however long the strobes are held
  always_comb begin
    state_n = state;
    base_n = base;
    base_lo_n = base_lo;
    wr_done_n = wr_done && !AS_n;
    if (commit) begin
      wr_done_n = 1'b1;
      base_lo_n = off == 6'h25 ? DIN : base_lo;
      base_n = off == 6'h24 ? {DIN, base_lo} : base;
      state_n = off == 6'h24 ? CONFIGURED : off == 6'h26 ? SHUTUP : state;
    end
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= UNCONFIG;
      base <= 8'h00;
      base_lo <= 4'h0;
      wr_done <= 1'b0;
    end else begin
      state <= state_n;
      base <= base_n;
      base_lo <= base_lo_n;
      wr_done <= wr_done_n;
    end
  end
endmodule

// File: tb/tb_zorro2_autoconfig.sv
// tb_zorro2_autoconfig: directed scoreboard bench for the AutoConfig responder
module tb_zorro2_autoconfig;
  logic CLK = 1'b0, RESET = 1'b1;
  logic [23:1] ADDR = '0;
  logic [3:0] DIN = '0;
  logic AS_n = 1'b1, UDS_n = 1'b1, LDS_n = 1'b1, RW = 1'b1, CFGIN_n = 1'b0;
  logic CFGOUT_n, DOE, ide_access, ide_enable, configured;
  logic [3:0] DOUT;
  int checks = 0, failures = 0;
  logic [8:0] exp_q[$];
  string tag_q[$];
  zorro2_autoconfig dut (
    .CLK(CLK), .RESET(RESET), .ADDR(ADDR), .DIN(DIN), .AS_n(AS_n), .UDS_n(UDS_n),
    .LDS_n(LDS_n), .RW(RW), .CFGIN_n(CFGIN_n), .CFGOUT_n(CFGOUT_n), .DOUT(DOUT),
    .DOE(DOE), .ide_access(ide_access), .ide_enable(ide_enable), .configured(configured)
  );
  always #5 CLK = ~CLK;
  function automatic logic [8:0] ex(logic doe, logic [3:0] d, logic a, logic n, logic c, logic o);
    return {doe, d, a, n, c, o};
  endfunction
  task automatic push(string tag, logic [8:0] e);
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask
  task automatic pop_check();
    logic [8:0] e, obs;
    string tag;
    e = exp_q.pop_front();
    tag = tag_q.pop_front();
    obs = {DOE, DOUT, ide_access, ide_enable, configured, CFGOUT_n};
    checks++;
    assert (obs === e) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b (doe,dout,acc,en,cfg,cfgout_n)", tag, obs, e);
    end
  endtask
  task automatic sample(string tag, logic [8:0] e);
    push(tag, e);
    #2 pop_check();
  endtask
  task automatic rd(string tag, logic [23:0] a, logic [8:0] e);
    @(negedge CLK);
    ADDR = a[23:1]; RW = 1'b1; AS_n = 1'b0; UDS_n = 1'b0;
    sample(tag, e);
    @(negedge CLK);
    AS_n = 1'b1; UDS_n = 1'b1;
  endtask
  task automatic wr(logic [23:0] a, logic [3:0] d);
    @(negedge CLK);
    ADDR = a[23:1]; DIN = d; RW = 1'b0; AS_n = 1'b0; UDS_n = 1'b0;
    @(negedge CLK);
    AS_n = 1'b1; UDS_n = 1'b1; RW = 1'b1;
  endtask
  task automatic do_reset();
    @(negedge CLK);
    RESET = 1'b1; AS_n = 1'b1; UDS_n = 1'b1; RW = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
  endtask
  initial begin
    logic [23:0] ad;
    localparam logic [8:0] UNC = 9'b0_0000_0001;
    do_reset();
    sample("reset_state", UNC);
    rd("rom_reg0_hi", 24'hE80000, ex(1, 4'hD, 0, 0, 0, 1));
    rd("rom_reg0_lo", 24'hE80002, ex(1, 4'h1, 0, 0, 0, 1));
    rd("rom_prod_lo", 24'hE80006, ex(1, 4'hA, 0, 0, 0, 1));
    rd("rom_flags_lo", 24'hE8000A, ex(1, 4'hF, 0, 0, 0, 1));
    rd("rom_manuf_hi", 24'hE80010, ex(1, 4'hF, 0, 0, 0, 1));
    rd("rom_manuf_lo_lo", 24'hE80016, ex(1, 4'h4, 0, 0, 0, 1));
    rd("rom_serial_last_lo", 24'hE80026, ex(1, 4'hE, 0, 0, 0, 1));
    rd("rom_reg16", 24'hE80040, ex(1, 4'h0, 0, 0, 0, 1));
    CFGIN_n = 1'b1;
    rd("cfgin_high_read", 24'hE80000, ex(0, 4'h0, 0, 0, 0, 1));
    wr(24'hE80048, 4'hE);
    sample("cfgin_high_write", UNC);
    CFGIN_n = 1'b0;
    @(negedge CLK);
    ADDR = 24'h710025 >> 0; ad = 24'hE8004A;
    ADDR = ad[23:1]; DIN = 4'h3; RW = 1'b0; AS_n = 1'b0; UDS_n = 1'b0;
    @(negedge CLK);
    DIN = 4'h7;
    repeat (5) @(negedge CLK);
    AS_n = 1'b1; UDS_n = 1'b1; RW = 1'b1;
    wr(24'hE80048, 4'hE);
    rd("hold_single_commit_hit", 24'hE30000, ex(0, 4'h0, 1, 0, 1, 0));
    rd("hold_single_commit_miss", 24'hE70000, ex(0, 4'h0, 0, 0, 1, 0));
    do_reset();
    sample("reset_again", UNC);
    @(negedge CLK);
    ad = 24'hE8004A;
    ADDR = ad[23:1]; DIN = 4'h3; RW = 1'b0; AS_n = 1'b0; UDS_n = 1'b0;
    repeat (6) @(negedge CLK);
    AS_n = 1'b1; UDS_n = 1'b1; RW = 1'b1;
    wr(24'hE8004A, 4'h9);
    @(negedge CLK);
    ad = 24'hE80048;
    ADDR = ad[23:1]; DIN = 4'hE; RW = 1'b0; AS_n = 1'b0; UDS_n = 1'b0;
    sample("pre_commit_unconfig", UNC);
    @(posedge CLK);
    sample("post_commit_configured", ex(0, 4'h0, 0, 0, 1, 0));
    @(negedge CLK);
    AS_n = 1'b1; UDS_n = 1'b1; RW = 1'b1;
    rd("win_low_half", 24'hE91000, ex(0, 4'h0, 1, 0, 1, 0));
    rd("win_enable_half", 24'hE98000, ex(0, 4'h0, 1, 1, 1, 0));
    rd("outside_window", 24'hE81000, ex(0, 4'h0, 0, 0, 1, 0));
    wr(24'hE8004A, 4'h3);
    wr(24'hE80048, 4'h1);
    rd("configured_ignores_writes", 24'hE90000, ex(0, 4'h0, 1, 0, 1, 0));
    sample("no_strobe_no_access", ex(0, 4'h0, 0, 0, 1, 0));
    @(negedge CLK);
    ad = 24'hE91000;
    ADDR = ad[23:1]; RW = 1'b1; AS_n = 1'b0; UDS_n = 1'b0;
    sample("mid_cycle_before_reset", ex(0, 4'h0, 1, 0, 1, 0));
    RESET = 1'b1;
    @(posedge CLK);
    sample("mid_cycle_after_reset", UNC);
    @(negedge CLK);
    RESET = 1'b0; AS_n = 1'b1; UDS_n = 1'b1;
    rd("rom_after_reset", 24'hE80000, ex(1, 4'hD, 0, 0, 0, 1));
    wr(24'hE80048, 4'hE);
    rd("base_lo_cleared_hit", 24'hE00000, ex(0, 4'h0, 1, 0, 1, 0));
    rd("base_lo_cleared_miss", 24'hE90000, ex(0, 4'h0, 0, 0, 1, 0));
    do_reset();
    wr(24'hE8004C, 4'h0);
    sample("shutup_state", ex(0, 4'h0, 0, 0, 0, 0));
    rd("shutup_rom_hidden", 24'hE80000, ex(0, 4'h0, 0, 0, 0, 0));
    wr(24'hE80048, 4'hE);
    rd("shutup_ignores_48", 24'hE90000, ex(0, 4'h0, 0, 0, 0, 0));
    rd("shutup_no_access_e0", 24'hE00000, ex(0, 4'h0, 0, 0, 0, 0));
    checks++;
    assert (exp_q.size() === 0) else begin
      failures++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
